// File: rtl/acc_pkg.sv
// Shared definitions for the accelerometer triplet framer.
//   ACC_DW          : default signed sample width
//   AXIS_*          : axis tag encodings carried on in_axis
//   acc_frm_state_t : framing state (which axis is expected next)
package acc_pkg;

  localparam int unsigned ACC_DW = 16;

  localparam logic [1:0] AXIS_X    = 2'd0;
  localparam logic [1:0] AXIS_Y    = 2'd1;
  localparam logic [1:0] AXIS_Z    = 2'd2;
  localparam logic [1:0] AXIS_RSVD = 2'd3;

  typedef enum logic [1:0] {
    StWaitX = 2'd0,
    StWaitY = 2'd1,
    StWaitZ = 2'd2
  } acc_frm_state_t;

endpackage

// File: rtl/acc_triplet_framer_if.sv
// Sample-in / triplet-out bus of the accelerometer triplet framer.
//   in_valid/in_ready/in_axis/in_data : axis-tagged raw sample stream
//   out_valid/out_ready/acc_x/y/z     : averaged, offset-corrected triplet
// Modports: master = source/sink side, slave = framer side.
interface acc_triplet_framer_if
  import acc_pkg::*;
#(
  parameter int unsigned DW = ACC_DW
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_axis;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] acc_x;
  logic signed [DW-1:0] acc_y;
  logic signed [DW-1:0] acc_z;

  modport master (
    output in_valid, in_axis, in_data, out_ready,
    input  in_ready, out_valid, acc_x, acc_y, acc_z
  );

  modport slave (
    input  in_valid, in_axis, in_data, out_ready,
    output in_ready, out_valid, acc_x, acc_y, acc_z
  );

endinterface

// File: rtl/acc_axis_avg.sv
// One axis of the framer: box-car accumulator, average, offset subtract and
// reduction to DW bits (saturating when ACC_TRIPLET_FRAMER_SAT_EN is defined,
// wrapping otherwise).
//   clk, rst_n : clock, async active-low reset
//   add_en     : add sample into the accumulator this cycle
//   clr        : clear the accumulator (after this cycle's add is consumed)
//   dump       : register the result formed from accumulator + this cycle's add
//   sample     : signed sample to add
//   offset     : signed calibration offset, sampled on dump
//   result     : registered averaged, corrected value
module acc_axis_avg
  import acc_pkg::*;
#(
  parameter int unsigned DW       = ACC_DW,
  parameter int unsigned LOG2_AVG = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 add_en,
  input  logic                 clr,
  input  logic                 dump,
  input  logic signed [DW-1:0] sample,
  input  logic signed [DW-1:0] offset,
  output logic signed [DW-1:0] result
);

  localparam int unsigned AW = DW + LOG2_AVG;

  logic signed [AW-1:0] acc_q, acc_d, sum;
  logic signed [DW-1:0] avg;
  logic signed [DW:0]   diff;
  logic signed [DW-1:0] red;
  logic signed [DW-1:0] result_q;

  always_comb begin
    sum = acc_q;
    if (add_en) begin
      sum = acc_q + AW'($signed(sample));
    end
    acc_d = clr ? '0 : sum;
    // The mean of DW-bit values always fits in DW bits, so truncation is exact.
    avg  = DW'(sum >>> LOG2_AVG);
    diff = (DW + 1)'(avg) - (DW + 1)'(offset);
    red  = DW'(diff);
`ifdef ACC_TRIPLET_FRAMER_SAT_EN
    if (diff[DW] != diff[DW-1]) begin
      red = diff[DW] ? {1'b1, {(DW - 1){1'b0}}} : {1'b0, {(DW - 1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (dump) begin
        result_q <= red;
      end
    end
  end

  assign result = result_q;

endmodule

// File: rtl/acc_triplet_framer.sv
// Accelerometer triplet framer: assembles axis-tagged samples into ordered
// X,Y,Z triplets, averages 2^LOG2_AVG triplets, subtracts per-axis offsets and
// presents one triplet per beat on a valid/ready handshake.
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : sample input stream and triplet output stream
//   off_x, off_y, off_z : signed offsets, sampled when an output beat forms
//   frame_err           : one-cycle pulse on an axis-order violation
// Build option: define ACC_TRIPLET_FRAMER_SAT_EN to saturate results instead of
// wrapping them.
module acc_triplet_framer
  import acc_pkg::*;
#(
  parameter int unsigned DW       = ACC_DW,
  parameter int unsigned LOG2_AVG = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  acc_triplet_framer_if.slave  bus,
  input  logic signed [DW-1:0] off_x,
  input  logic signed [DW-1:0] off_y,
  input  logic signed [DW-1:0] off_z,
  output logic                 frame_err
);

  localparam int unsigned CW = LOG2_AVG + 1;
  localparam logic [CW-1:0] CntLast = CW'((1 << LOG2_AVG) - 1);

  acc_frm_state_t       state_q;
  logic [CW-1:0]        cnt_q;
  // X and Y are staged until Z arrives so a broken triplet never reaches the
  // accumulators.
  logic signed [DW-1:0] stage_x_q, stage_y_q;
  logic                 out_valid_q;
  logic                 frame_err_q;

  logic accept, tag_match, z_done, done;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign frame_err     = frame_err_q;

  always_comb begin
    accept    = bus.in_valid && bus.in_ready;
    tag_match = 1'b0;
    case (state_q)
      StWaitX: tag_match = (bus.in_axis == AXIS_X);
      StWaitY: tag_match = (bus.in_axis == AXIS_Y);
      StWaitZ: tag_match = (bus.in_axis == AXIS_Z);
      default: tag_match = 1'b0;
    endcase
    z_done = accept && tag_match && (state_q == StWaitZ);
    done   = z_done && (cnt_q == CntLast);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWaitX;
      cnt_q       <= '0;
      stage_x_q   <= '0;
      stage_y_q   <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= accept && !tag_match;
      if (accept) begin
        if (bus.in_axis == AXIS_X) begin
          // Either the expected X or a resync: both start a new triplet.
          stage_x_q <= bus.in_data;
          state_q   <= StWaitY;
        end else if (tag_match && (state_q == StWaitY)) begin
          stage_y_q <= bus.in_data;
          state_q   <= StWaitZ;
        end else begin
          state_q <= StWaitX;
        end
      end
      if (z_done) begin
        cnt_q <= done ? '0 : cnt_q + 1'b1;
      end
      if (done) begin
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  acc_axis_avg #(
    .DW       (DW),
    .LOG2_AVG (LOG2_AVG)
  ) u_avg_x (
    .clk    (clk),
    .rst_n  (rst_n),
    .add_en (z_done),
    .clr    (done),
    .dump   (done),
    .sample (stage_x_q),
    .offset (off_x),
    .result (bus.acc_x)
  );

  acc_axis_avg #(
    .DW       (DW),
    .LOG2_AVG (LOG2_AVG)
  ) u_avg_y (
    .clk    (clk),
    .rst_n  (rst_n),
    .add_en (z_done),
    .clr    (done),
    .dump   (done),
    .sample (stage_y_q),
    .offset (off_y),
    .result (bus.acc_y)
  );

  acc_axis_avg #(
    .DW       (DW),
    .LOG2_AVG (LOG2_AVG)
  ) u_avg_z (
    .clk    (clk),
    .rst_n  (rst_n),
    .add_en (z_done),
    .clr    (done),
    .dump   (done),
    .sample (bus.in_data),
    .offset (off_z),
    .result (bus.acc_z)
  );

endmodule

// File: tb/tb_acc_triplet_framer.sv
// Scoreboard bench for acc_triplet_framer: instance A averages 4 triplets,
// instance B passes every triplet through. Expected beats are queued as the
// stimulus is issued; monitors pop and compare on every output transfer.
module tb_acc_triplet_framer;
  import acc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [15:0] offa_x, offa_y, offa_z, offb_x, offb_y, offb_z;
  logic ferr_a, ferr_b;

  int checks = 0;
  int failures = 0;
  int err_seen_a = 0;
  int err_seen_b = 0;

  typedef struct {
    longint x;
    longint y;
    longint z;
  } trip_t;
  trip_t qa[$];
  trip_t qb[$];

`ifdef ACC_TRIPLET_FRAMER_SAT_EN
  localparam longint OvfPos = 32767;
  localparam longint OvfNeg = -32768;
`else
  localparam longint OvfPos = -32768;
  localparam longint OvfNeg = 32767;
`endif

  always #5 clk = ~clk;

  acc_triplet_framer_if #(.DW(16)) ba ();
  acc_triplet_framer_if #(.DW(16)) bb ();

  acc_triplet_framer #(.DW(16), .LOG2_AVG(2)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ba),
    .off_x     (offa_x),
    .off_y     (offa_y),
    .off_z     (offa_z),
    .frame_err (ferr_a)
  );

  acc_triplet_framer #(.DW(16), .LOG2_AVG(0)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bb),
    .off_x     (offb_x),
    .off_y     (offb_y),
    .off_z     (offb_z),
    .frame_err (ferr_b)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input bit sel, input longint x, input longint y,
                               input longint z);
    trip_t t;
    t.x = x;
    t.y = y;
    t.z = z;
    if (sel) qb.push_back(t);
    else qa.push_back(t);
  endfunction

  // Present one sample, wait (bounded) for acceptance, return 1ns after the edge.
  task automatic drive(input bit sel, input logic [1:0] ax, input logic signed [15:0] d);
    int n = 0;
    @(negedge clk);
    if (sel) begin
      bb.in_valid = 1'b1; bb.in_axis = ax; bb.in_data = d;
    end else begin
      ba.in_valid = 1'b1; ba.in_axis = ax; ba.in_data = d;
    end
    while (!(sel ? bb.in_ready : ba.in_ready) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++;
      failures++;
      $display("FAIL send_timeout sel=%0d in_ready=0 after %0d cycles", sel, n);
    end
    @(posedge clk);
    #1;
    if (sel) bb.in_valid = 1'b0;
    else ba.in_valid = 1'b0;
  endtask

  task automatic trip(input bit sel, input logic signed [15:0] x, input logic signed [15:0] y,
                      input logic signed [15:0] z);
    drive(sel, AXIS_X, x);
    drive(sel, AXIS_Y, y);
    drive(sel, AXIS_Z, z);
  endtask

  // Outputs are stable between posedges; a beat seen here transfers at the next edge.
  always @(negedge clk) begin
    trip_t e;
    if (rst_n) begin
      if (ferr_a) err_seen_a++;
      if (ferr_b) err_seen_b++;
      if (ba.out_valid && ba.out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_beat actual=(%0d,%0d,%0d) expected=none",
                   ba.acc_x, ba.acc_y, ba.acc_z);
        end else begin
          e = qa.pop_front();
          chk("a_acc_x", ba.acc_x, e.x);
          chk("a_acc_y", ba.acc_y, e.y);
          chk("a_acc_z", ba.acc_z, e.z);
        end
      end
      if (bb.out_valid && bb.out_ready) begin
        if (qb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_beat actual=(%0d,%0d,%0d) expected=none",
                   bb.acc_x, bb.acc_y, bb.acc_z);
        end else begin
          e = qb.pop_front();
          chk("b_acc_x", bb.acc_x, e.x);
          chk("b_acc_y", bb.acc_y, e.y);
          chk("b_acc_z", bb.acc_z, e.z);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] xs [4];
    logic signed [15:0] ys [4];
    ba.in_valid = 1'b0; ba.in_axis = '0; ba.in_data = '0; ba.out_ready = 1'b1;
    bb.in_valid = 1'b0; bb.in_axis = '0; bb.in_data = '0; bb.out_ready = 1'b1;
    offa_x = '0; offa_y = '0; offa_z = '0;
    offb_x = '0; offb_y = '0; offb_z = '0;
    xs = '{16'sd1, 16'sd2, 16'sd3, 16'sd5};
    ys = '{-16'sd1, -16'sd1, -16'sd1, -16'sd2};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("a_rst_out_valid", ba.out_valid, 0);
    chk("a_rst_acc_x", ba.acc_x, 0);
    chk("a_rst_in_ready", ba.in_ready, 1);
    chk("b_rst_out_valid", bb.out_valid, 0);
    chk("b_rst_acc_z", bb.acc_z, 0);
    chk("b_rst_frame_err", ferr_b, 0);

    // Four identical triplets average to themselves; beat only after the 4th Z.
    push(0, 100, -8, 4000);
    for (int i = 0; i < 4; i++) begin
      trip(0, 100, -8, 4000);
      chk("a_valid_after_z", ba.out_valid, (i == 3) ? 1 : 0);
    end

    // Floor averaging, offsets, and Z overflow past the positive limit.
    offa_x = -16'sd3;
    offa_z = -16'sd1;
    push(0, 5, -2, OvfPos);
    for (int i = 0; i < 4; i++) trip(0, xs[i], ys[i], 16'sd32767);

    // Pass-through with offsets.
    offb_x = 16'sd10; offb_y = 16'sd10; offb_z = 16'sd10;
    push(1, -5, 10, -13);
    trip(1, 5, 20, -3);

    // Early Z breaks the triplet; the following X starts afresh.
    offb_x = '0; offb_y = '0; offb_z = '0;
    push(1, 7, 9, 7);
    drive(1, AXIS_X, 7);
    drive(1, AXIS_Z, 55);
    chk("b_frame_err_pulse", ferr_b, 1);
    trip(1, 7, 9, 7);
    // Reserved tag, then an X arriving mid-triplet (resync).
    push(1, 1, 2, 3);
    drive(1, AXIS_RSVD, 1);
    trip(1, 1, 2, 3);
    push(1, 4, 5, 6);
    drive(1, AXIS_X, 50);
    drive(1, AXIS_Y, 60);
    trip(1, 4, 5, 6);

    // Result overflow in both directions.
    offb_x = -16'sd1;
    push(1, OvfPos, 0, 0);
    trip(1, 32767, 0, 0);
    offb_x = 16'sd1;
    push(1, OvfNeg, 0, 0);
    trip(1, -32768, 0, 0);
    offb_x = '0;

    // Backpressure: held beat blocks input until out_ready returns.
    @(posedge clk);
    #2 bb.out_ready = 1'b0;
    push(1, 11, -12, 13);
    trip(1, 11, -12, 13);
    push(1, 21, 22, 23);
    fork
      trip(1, 21, 22, 23);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("b_bp_in_ready", bb.in_ready, 0);
          chk("b_bp_hold_valid", bb.out_valid, 1);
          chk("b_bp_hold_x", bb.acc_x, 11);
          chk("b_bp_hold_y", bb.acc_y, -12);
        end
        @(posedge clk);
        #2 bb.out_ready = 1'b1;
      end
    join

    // Reset with a partial triplet on A and a held beat on B.
    drive(0, AXIS_X, 1000);
    drive(0, AXIS_Y, 1000);
    @(posedge clk);
    #2 bb.out_ready = 1'b0;
    trip(1, 1, 1, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("a_midrst_out_valid", ba.out_valid, 0);
    chk("a_midrst_acc_x", ba.acc_x, 0);
    chk("b_midrst_out_valid", bb.out_valid, 0);
    chk("b_midrst_acc_x", bb.acc_x, 0);
    chk("b_midrst_acc_y", bb.acc_y, 0);
    chk("b_midrst_acc_z", bb.acc_z, 0);
    bb.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("a_post_rst_in_ready", ba.in_ready, 1);
    chk("b_post_rst_in_ready", bb.in_ready, 1);

    offa_x = '0; offa_z = '0;
    push(0, -4, 6, 8);
    for (int i = 0; i < 4; i++) trip(0, -4, 6, 8);
    push(1, 3, -3, 9);
    trip(1, 3, -3, 9);

    repeat (5) @(negedge clk);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    chk("a_err_count", err_seen_a, 0);
    chk("b_err_count", err_seen_b, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
